// File: rtl/hazard_detection.sv
// Pipeline hazard unit: picks one of WAIT/FLUSH/LU/RUN each cycle, drives the
// stall/flush controls combinationally and keeps saturating performance counters.
module hazard_detection #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_ex_memread_i,
    input  logic [4:0]       id_ex_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             pipe_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_timeout_o
);

    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_LU = 2'd1,
        WAIT_MEM = 2'd2,
        FLUSH    = 2'd3
    } action_t;

    action_t           action_p0;
    action_t           state_p1;
    logic              cond_wait;
    logic              cond_lu;
    logic [WAIT_W-1:0] wait_cnt_p1;
    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  stall_cnt_p1;
    logic [CNT_W-1:0]  flush_cnt_p1;
    logic              mem_timeout_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_wait_inc(input logic [WAIT_W-1:0] v);
        return (v >= TIMEOUT_V) ? TIMEOUT_V : v + WAIT_W'(1);
    endfunction

    // Stage 0: combinational hazard decision, priority WAIT > FLUSH > LU > RUN
    always_comb begin
        cond_wait = mem_req_i && !mem_ready_i;
        // Register 0 is hardwired, so a load targeting it never creates a hazard
        cond_lu   = id_ex_memread_i && (id_ex_rt_i != 5'd0) &&
                    ((id_ex_rt_i == if_id_rs_i) ||
                     (id_uses_rt_i && (id_ex_rt_i == if_id_rt_i)));

        action_p0      = RUN;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        pipe_hold_o    = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;

        if (cond_wait) begin
            action_p0     = WAIT_MEM;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            pipe_hold_o   = 1'b1;
        end else if (branch_taken_i) begin
            action_p0      = FLUSH;
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
        end else if (cond_lu) begin
            action_p0     = STALL_LU;
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    assign wait_inc = sat_wait_inc(wait_cnt_p1);

    // Stage 1: registered action and statistics
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p1 <= RUN;
        end else begin
            state_p1 <= action_p0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_p1   <= '0;
            flush_cnt_p1   <= '0;
            wait_cnt_p1    <= '0;
            mem_timeout_p1 <= 1'b0;
        end else begin
            if ((action_p0 == WAIT_MEM) || (action_p0 == STALL_LU)) begin
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
            end
            if (action_p0 == FLUSH) begin
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
            end
            // Only an unbroken run of WAIT cycles counts toward the timeout
            if (action_p0 == WAIT_MEM) begin
                wait_cnt_p1 <= wait_inc;
                if (wait_inc == TIMEOUT_V) begin
                    mem_timeout_p1 <= 1'b1;
                end
            end else begin
                wait_cnt_p1 <= '0;
            end
        end
    end

    assign state_o       = state_p1;
    assign stall_cnt_o   = stall_cnt_p1;
    assign flush_cnt_o   = flush_cnt_p1;
    assign mem_timeout_o = mem_timeout_p1;

endmodule

// File: tb/tb_hazard_detection.sv
// Directed bench for hazard_detection: a default-parameter instance and a
// small one (TIMEOUT=4, CNT_W=2) share the same stimulus.
module tb_hazard_detection;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic       id_uses_rt, id_ex_memread, branch_taken, mem_req, mem_ready;

    logic        pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        mem_timeout;

    logic        pc_write_s, if_id_write_s, pipe_hold_s, if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;
    logic [1:0]  state_s;
    logic [1:0]  stall_cnt_s, flush_cnt_s;
    logic        mem_timeout_s;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_detection dut (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .id_uses_rt_i(id_uses_rt),
        .id_ex_memread_i(id_ex_memread), .id_ex_rt_i(id_ex_rt),
        .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write), .pipe_hold_o(pipe_hold),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .ex_mem_flush_o(ex_mem_flush),
        .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .mem_timeout_o(mem_timeout)
    );

    hazard_detection #(.TIMEOUT(4), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt), .id_uses_rt_i(id_uses_rt),
        .id_ex_memread_i(id_ex_memread), .id_ex_rt_i(id_ex_rt),
        .branch_taken_i(branch_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write_s), .if_id_write_o(if_id_write_s), .pipe_hold_o(pipe_hold_s),
        .if_id_flush_o(if_id_flush_s), .id_ex_flush_o(id_ex_flush_s), .ex_mem_flush_o(ex_mem_flush_s),
        .state_o(state_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s),
        .mem_timeout_o(mem_timeout_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_id_rs = 5'd0; if_id_rt = 5'd0; id_uses_rt = 1'b0;
        id_ex_memread = 1'b0; id_ex_rt = 5'd0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt_id, input logic uses_rt,
                          input logic [4:0] ex_rt);
        id_ex_memread = 1'b1; if_id_rs = rs; if_id_rt = rt_id;
        id_uses_rt = uses_rt; id_ex_rt = ex_rt;
    endtask

    task automatic test_reset();
        logic [5:0] ctl;
        idle();
        mem_req = 1'b1;
        rst = 1'b1;
        tick(); tick();
        set_lu(5'd7, 5'd0, 1'b0, 5'd7);
        mem_req = 1'b0;
        #1;
        ctl = {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush};
        total++; if (ctl !== 6'b000010) $display("FAIL reset_comb_follow got=%b exp=%b", ctl, 6'b000010); else passed++;
        tick();
        total++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
        total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); else passed++;
        total++; if (mem_timeout !== 1'b0 || mem_timeout_s !== 1'b0) $display("FAIL reset_timeout got=%b%b exp=00", mem_timeout, mem_timeout_s); else passed++;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        logic [5:0] ctl;
        do_reset();
        set_lu(5'd5, 5'd0, 1'b0, 5'd5);
        #1;
        ctl = {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush};
        total++; if (ctl !== 6'b000010) $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, 6'b000010); else passed++;
        tick();
        total++; if (state !== 2'd1) $display("FAIL lu_rs_state got=%0d exp=1", state); else passed++;
        total++; if (stall_cnt !== 16'd1) $display("FAIL lu_rs_stall got=%0d exp=1", stall_cnt); else passed++;
        set_lu(5'd3, 5'd9, 1'b1, 5'd9);
        #1;
        total++; if (pc_write !== 1'b0 || id_ex_flush !== 1'b1) $display("FAIL lu_rt_ctl got=%b%b exp=01", pc_write, id_ex_flush); else passed++;
        tick();
        set_lu(5'd3, 5'd9, 1'b0, 5'd9);
        #1;
        total++; if (pc_write !== 1'b1 || id_ex_flush !== 1'b0) $display("FAIL lu_rt_unused_ctl got=%b%b exp=10", pc_write, id_ex_flush); else passed++;
        tick();
        total++; if (state !== 2'd0 || stall_cnt !== 16'd2) $display("FAIL lu_rt_unused_reg got=%0d/%0d exp=0/2", state, stall_cnt); else passed++;
        idle();
    endtask

    task automatic test_reg_zero();
        logic [5:0] ctl;
        do_reset();
        set_lu(5'd0, 5'd0, 1'b1, 5'd0);
        #1;
        ctl = {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush};
        total++; if (ctl !== 6'b110000) $display("FAIL reg0_ctl got=%b exp=%b", ctl, 6'b110000); else passed++;
        tick();
        total++; if (state !== 2'd0 || stall_cnt !== 16'd0) $display("FAIL reg0_reg got=%0d/%0d exp=0/0", state, stall_cnt); else passed++;
        idle();
    endtask

    task automatic test_flush_priority();
        logic [5:0] ctl;
        do_reset();
        set_lu(5'd5, 5'd0, 1'b0, 5'd5);
        branch_taken = 1'b1;
        #1;
        ctl = {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush};
        total++; if (ctl !== 6'b110111) $display("FAIL flush_ctl got=%b exp=%b", ctl, 6'b110111); else passed++;
        tick();
        total++; if (state !== 2'd3) $display("FAIL flush_state got=%0d exp=3", state); else passed++;
        total++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) $display("FAIL flush_counts got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); else passed++;
        idle();
    endtask

    task automatic test_wait();
        logic [5:0] ctl;
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            // A taken branch and a load-use both lose to the memory wait
            branch_taken = (i == 1);
            if (i == 2) set_lu(5'd4, 5'd0, 1'b0, 5'd4);
            #1;
            ctl = {pc_write, if_id_write, pipe_hold, if_id_flush, id_ex_flush, ex_mem_flush};
            total++; if (ctl !== 6'b001000) $display("FAIL wait_ctl[%0d] got=%b exp=%b", i, ctl, 6'b001000); else passed++;
            tick();
            total++; if (state !== 2'd2) $display("FAIL wait_state[%0d] got=%0d exp=2", i, state); else passed++;
        end
        idle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        total++; if (pipe_hold !== 1'b0 || pc_write !== 1'b1) $display("FAIL wait_release got=%b%b exp=01", pipe_hold, pc_write); else passed++;
        tick();
        total++; if (state !== 2'd0 || stall_cnt !== 16'd3 || flush_cnt !== 16'd0) $display("FAIL wait_after got=%0d/%0d/%0d exp=0/3/0", state, stall_cnt, flush_cnt); else passed++;
        total++; if (mem_timeout_s !== 1'b0) $display("FAIL wait_no_timeout got=%b exp=0", mem_timeout_s); else passed++;
        idle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1;
        tick(); tick(); tick();
        total++; if (mem_timeout_s !== 1'b0) $display("FAIL tmo_before got=%b exp=0", mem_timeout_s); else passed++;
        tick();
        total++; if (mem_timeout_s !== 1'b1) $display("FAIL tmo_set got=%b exp=1", mem_timeout_s); else passed++;
        mem_ready = 1'b1;
        #1;
        total++; if (pc_write_s !== 1'b1 || pipe_hold_s !== 1'b0) $display("FAIL tmo_ctl got=%b%b exp=10", pc_write_s, pipe_hold_s); else passed++;
        tick();
        total++; if (mem_timeout_s !== 1'b1 || state_s !== 2'd0) $display("FAIL tmo_sticky got=%b/%0d exp=1/0", mem_timeout_s, state_s); else passed++;
        do_reset();
        total++; if (mem_timeout_s !== 1'b0) $display("FAIL tmo_reset got=%b exp=0", mem_timeout_s); else passed++;
        // A broken run restarts the count
        mem_req = 1'b1;
        tick(); tick(); tick();
        mem_req = 1'b0;
        tick();
        mem_req = 1'b1;
        tick(); tick(); tick();
        total++; if (mem_timeout_s !== 1'b0) $display("FAIL tmo_broken_run got=%b exp=0", mem_timeout_s); else passed++;
        // Reset in mid-run also restarts the count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        total++; if (mem_timeout_s !== 1'b0) $display("FAIL tmo_reset_run got=%b exp=0", mem_timeout_s); else passed++;
        tick();
        total++; if (mem_timeout_s !== 1'b1) $display("FAIL tmo_reset_run4 got=%b exp=1", mem_timeout_s); else passed++;
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        total++; if (mem_timeout !== 1'b0) $display("FAIL tmo255_before got=%b exp=0", mem_timeout); else passed++;
        tick();
        total++; if (mem_timeout !== 1'b1 || stall_cnt !== 16'd255) $display("FAIL tmo255_set got=%b/%0d exp=1/255", mem_timeout, stall_cnt); else passed++;
        idle();
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu(5'd6, 5'd0, 1'b0, 5'd6);
        for (int i = 0; i < 5; i++) tick();
        total++; if (stall_cnt_s !== 2'd3) $display("FAIL stall_sat got=%0d exp=3", stall_cnt_s); else passed++;
        total++; if (stall_cnt !== 16'd5) $display("FAIL stall_wide got=%0d exp=5", stall_cnt); else passed++;
        idle();
        branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++; if (flush_cnt_s !== 2'd3 || flush_cnt !== 16'd5) $display("FAIL flush_sat got=%0d/%0d exp=3/5", flush_cnt_s, flush_cnt); else passed++;
        idle();
    endtask

    task automatic test_back_to_back();
        // Rows: LU via rs, FLUSH, WAIT, RUN, LU via rt
        logic [1:0] exp_state [5] = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
        logic       exp_pc    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: set_lu(5'd8, 5'd0, 1'b0, 5'd8);
                1: branch_taken = 1'b1;
                2: mem_req = 1'b1;
                4: set_lu(5'd1, 5'd12, 1'b1, 5'd12);
                default: ;
            endcase
            #1;
            total++; if (pc_write !== exp_pc[i]) $display("FAIL b2b_pc[%0d] got=%b exp=%b", i, pc_write, exp_pc[i]); else passed++;
            tick();
            total++; if (state !== exp_state[i]) $display("FAIL b2b_state[%0d] got=%0d exp=%0d", i, state, exp_state[i]); else passed++;
        end
        total++; if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1) $display("FAIL b2b_counts got=%0d/%0d exp=3/1", stall_cnt, flush_cnt); else passed++;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_reg_zero();
        test_flush_priority();
        test_wait();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_detection.md
HAZARD_DETECTION -- requirements
Module: hazard_detection

Interface
REQ-001 Parameter TIMEOUT, default 255, the number of consecutive memory-wait cycles after which mem_timeout_o sets.
REQ-002 Parameter CNT_W, default 16, the width of each performance counter.
REQ-003 clk_i  in  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 if_id_rs_i  in  5  rs field of the instruction in ID.
REQ-006 if_id_rt_i  in  5  rt field of the instruction in ID.
REQ-007 id_uses_rt_i  in  1  ID instruction reads rt as a source.
REQ-008 id_ex_memread_i  in  1  instruction in EX is a load.
REQ-009 id_ex_rt_i  in  5  load destination register in EX.
REQ-010 branch_taken_i  in  1  branch in MEM resolved taken this cycle.
REQ-011 mem_req_i  in  1  MEM stage is accessing data memory.
REQ-012 mem_ready_i  in  1  data memory completes the access this cycle.
REQ-013 pc_write_o  out  1  PC may update.
REQ-014 if_id_write_o  out  1  IF/ID may update.
REQ-015 pipe_hold_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-016 if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  insert a bubble into that pipeline register.
REQ-017 state_o  out  2  action of the previous cycle: 0 RUN, 1 STALL_LU, 2 WAIT_MEM, 3 FLUSH.
REQ-018 stall_cnt_o, flush_cnt_o  out  CNT_W each  saturating performance counters.
REQ-019 mem_timeout_o  out  1  sticky memory-timeout flag.

Function
REQ-020 The unit SHALL evaluate the conditions below each cycle in priority order: WAIT, FLUSH, LU, RUN.
REQ-021 WAIT SHALL be mem_req_i and not mem_ready_i.
REQ-022 WAIT action: pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, all flushes 0.
REQ-023 FLUSH SHALL be branch_taken_i and not WAIT.
REQ-024 FLUSH action: pc_write_o=1, if_id_write_o=1, pipe_hold_o=0, if_id_flush_o, id_ex_flush_o and ex_mem_flush_o all 1.
REQ-025 LU SHALL be id_ex_memread_i and id_ex_rt_i!=0 and (id_ex_rt_i==if_id_rs_i or (id_uses_rt_i and id_ex_rt_i==if_id_rt_i)).
REQ-026 LU action: pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1, all other flushes 0, pipe_hold_o=0.
REQ-027 RUN action: pc_write_o=1, if_id_write_o=1, pipe_hold_o=0, all flushes 0.
REQ-028 All outputs other than state_o, the counters and mem_timeout_o SHALL be combinational, with zero-cycle latency.
REQ-029 state_o SHALL register the encoding of the selected action at every rising edge.
REQ-030 stall_cnt_o SHALL increment by 1 in each WAIT or LU cycle and saturate at all-ones.
REQ-031 flush_cnt_o SHALL increment by 1 in each FLUSH cycle and saturate at all-ones.
REQ-032 An internal wait counter SHALL increment each WAIT cycle, clear on any non-WAIT cycle, and saturate at TIMEOUT.
REQ-033 mem_timeout_o SHALL set on the edge where the wait counter reaches TIMEOUT and remain 1 until reset.
REQ-034 mem_timeout_o SHALL NOT alter any pipeline-control output.
REQ-035 If mem_req_i deasserts during WAIT, the next cycle SHALL be evaluated normally and the wait counter SHALL clear.
REQ-036 If LU and FLUSH coincide, FLUSH SHALL win and stall_cnt_o SHALL NOT increment.
REQ-037 Register 0 SHALL never cause LU.

Reset
REQ-038 While rst_i=1 at an edge, the next state SHALL be state_o=0, counters 0, wait counter 0 and mem_timeout_o=0.
REQ-039 Combinational outputs SHALL keep following their inputs during reset.
REQ-040 Reset asserted during a WAIT run SHALL clear the wait count, so a post-reset timeout requires TIMEOUT fresh WAIT cycles.

Verification
REQ-041 id_ex_memread=1, id_ex_rt=5, if_id_rs=5 -> pc_write=0, if_id_write=0, id_ex_flush=1; next cycle state_o=1, stall_cnt=1.
REQ-042 Same as REQ-041 with id_ex_rt=0 -> RUN outputs; stall_cnt unchanged.
REQ-043 LU condition plus branch_taken=1 -> all three flushes 1, pc_write=1; flush_cnt=1, stall_cnt=0.
REQ-044 mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_hold=1 for 3 cycles, then 0; stall_cnt=3; state_o sequence 2,2,2,0.
REQ-045 TIMEOUT=4, mem_ready=0 for 4 cycles -> mem_timeout=1 after the 4th edge and stays 1 after mem_ready=1; rst_i pulse clears it.
REQ-046 CNT_W=2, 5 LU cycles -> stall_cnt saturates at 3.
